// File: rtl/riscv_uop_pkg.sv
// Shared pipeline types for the in-order core.
// Provides the default data width, the register index type and the
// hardwired-zero register index used by the register file and scoreboard.
package riscv_uop_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/arf_scoreboard.sv
// Pending-write scoreboard for the architectural register file.
// One bit per register marks an in-flight producer. Bits are set by an
// issuing uop that writes a destination and cleared by the matching
// write-back; a new producer beats a same-cycle retire of the same register.
// Flush and reset clear everything.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_wb_en, i_wb_rd         write-back stream from retire
//   i_issue_valid            a uop leaves issue this cycle
//   i_issue_writes_rd        that uop writes i_issue_rd
//   i_issue_rd               destination of the issuing uop
//   i_flush                  clear all pending bits
//   i_rs1_addr, i_rs2_addr   source indices to check (RAW)
//   o_rs1_pending/o_rs2_pending  source has an outstanding producer
//   o_rd_pending             destination has an outstanding producer (WAW)
//   o_pending_cnt            population count of the registered bits
module arf_scoreboard
  import riscv_uop_pkg::*;
#(
  parameter int NREGS     = 32,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     i_wb_en,
  input  reg_idx_t i_wb_rd,
  input  logic     i_issue_valid,
  input  logic     i_issue_writes_rd,
  input  reg_idx_t i_issue_rd,
  input  logic     i_flush,
  input  reg_idx_t i_rs1_addr,
  input  reg_idx_t i_rs2_addr,
  output logic     o_rs1_pending,
  output logic     o_rs2_pending,
  output logic     o_rd_pending,
  output logic [5:0] o_pending_cnt
);

  logic [NREGS-1:0] sb_q;
  logic [NREGS-1:0] sb_d;
  logic [5:0]       cnt;

  always_comb begin
    sb_d = sb_q;
    for (int r = 1; r < NREGS; r++) begin
      // Clear first so a same-cycle set overrides it.
      if (i_wb_en && i_wb_rd == reg_idx_t'(r)) begin
        sb_d[r] = 1'b0;
      end
      if (i_issue_valid && i_issue_writes_rd && i_issue_rd == reg_idx_t'(r)) begin
        sb_d[r] = 1'b1;
      end
    end
    if (i_flush) begin
      sb_d = '0;
    end
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  // A producer retiring this cycle is forwarded on the read path, so it is
  // only masked when the bypass exists.
  function automatic logic pending_of(input reg_idx_t addr);
    logic p;
    p = 1'b0;
    if (addr != REG_ZERO && int'(addr) < NREGS) begin
      p = sb_q[addr];
    end
    if (WB_BYPASS && i_wb_en && i_wb_rd == addr) begin
      p = 1'b0;
    end
    return p;
  endfunction

  always_comb begin
    cnt = '0;
    for (int r = 0; r < NREGS; r++) begin
      cnt = cnt + 6'(sb_q[r]);
    end
  end

  // While reset is held the outputs reflect the cleared state immediately.
  assign o_rs1_pending = !rst && pending_of(i_rs1_addr);
  assign o_rs2_pending = !rst && pending_of(i_rs2_addr);
  assign o_rd_pending  = !rst && pending_of(i_issue_rd);
  assign o_pending_cnt = rst ? 6'd0 : cnt;

endmodule

// File: rtl/arf_regfile.sv
// Architectural register file with write-through bypass and a pending-write
// scoreboard for RAW/WAW hazard detection at issue.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   i_wb_en, i_wb_rd, i_wb_data      write-back from retire (x0 writes dropped)
//   i_rs1_addr/i_rs2_addr            combinational read port indices
//   o_rs1_data/o_rs2_data            read data (x0 reads 0)
//   o_rs1_pending/o_rs2_pending      source has an outstanding producer
//   i_issue_valid, i_issue_writes_rd, i_issue_rd   issuing uop destination
//   o_rd_pending                     destination already pending (WAW)
//   i_flush                          clear all pending state
//   o_pending_cnt                    number of pending registers
module arf_regfile
  import riscv_uop_pkg::*;
#(
  parameter int XLEN      = riscv_uop_pkg::XLEN,
  parameter int NREGS     = 32,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_wb_en,
  input  reg_idx_t        i_wb_rd,
  input  logic [XLEN-1:0] i_wb_data,
  input  reg_idx_t        i_rs1_addr,
  input  reg_idx_t        i_rs2_addr,
  output logic [XLEN-1:0] o_rs1_data,
  output logic [XLEN-1:0] o_rs2_data,
  output logic            o_rs1_pending,
  output logic            o_rs2_pending,
  input  logic            i_issue_valid,
  input  logic            i_issue_writes_rd,
  input  reg_idx_t        i_issue_rd,
  output logic            o_rd_pending,
  input  logic            i_flush,
  output logic [5:0]      o_pending_cnt
);

  // Flop storage: reset must clear every register, and reads are zero latency.
  logic [NREGS-1:0][XLEN-1:0] regs_q;
  logic [NREGS-1:0][XLEN-1:0] regs_d;

  always_comb begin
    regs_d = regs_q;
    for (int r = 1; r < NREGS; r++) begin
      if (i_wb_en && i_wb_rd == reg_idx_t'(r)) begin
        regs_d[r] = i_wb_data;
      end
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  function automatic logic [XLEN-1:0] read_port(input reg_idx_t addr);
    logic [XLEN-1:0] v;
    v = '0;
    if (addr == REG_ZERO || int'(addr) >= NREGS) begin
      v = '0;
    end else if (WB_BYPASS && i_wb_en && i_wb_rd == addr) begin
      v = i_wb_data;
    end else begin
      v = regs_q[addr];
    end
    return v;
  endfunction

  assign o_rs1_data = rst ? '0 : read_port(i_rs1_addr);
  assign o_rs2_data = rst ? '0 : read_port(i_rs2_addr);

  arf_scoreboard #(
    .NREGS     (NREGS),
    .WB_BYPASS (WB_BYPASS)
  ) u_scoreboard (
    .clk               (clk),
    .rst               (rst),
    .i_wb_en           (i_wb_en),
    .i_wb_rd           (i_wb_rd),
    .i_issue_valid     (i_issue_valid),
    .i_issue_writes_rd (i_issue_writes_rd),
    .i_issue_rd        (i_issue_rd),
    .i_flush           (i_flush),
    .i_rs1_addr        (i_rs1_addr),
    .i_rs2_addr        (i_rs2_addr),
    .o_rs1_pending     (o_rs1_pending),
    .o_rs2_pending     (o_rs2_pending),
    .o_rd_pending      (o_rd_pending),
    .o_pending_cnt     (o_pending_cnt)
  );

endmodule

// File: tb/tb_arf_regfile.sv
module tb_arf_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_wb_en;
  logic [4:0]  i_wb_rd;
  logic [31:0] i_wb_data;
  logic [4:0]  i_rs1_addr;
  logic [4:0]  i_rs2_addr;
  logic [31:0] o_rs1_data;
  logic [31:0] o_rs2_data;
  logic        o_rs1_pending;
  logic        o_rs2_pending;
  logic        i_issue_valid;
  logic        i_issue_writes_rd;
  logic [4:0]  i_issue_rd;
  logic        o_rd_pending;
  logic        i_flush;
  logic [5:0]  o_pending_cnt;

  always #5 clk = ~clk;

  arf_regfile #(
    .XLEN      (32),
    .NREGS     (32),
    .WB_BYPASS (1'b1)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .i_wb_en           (i_wb_en),
    .i_wb_rd           (i_wb_rd),
    .i_wb_data         (i_wb_data),
    .i_rs1_addr        (i_rs1_addr),
    .i_rs2_addr        (i_rs2_addr),
    .o_rs1_data        (o_rs1_data),
    .o_rs2_data        (o_rs2_data),
    .o_rs1_pending     (o_rs1_pending),
    .o_rs2_pending     (o_rs2_pending),
    .i_issue_valid     (i_issue_valid),
    .i_issue_writes_rd (i_issue_writes_rd),
    .i_issue_rd        (i_issue_rd),
    .o_rd_pending      (o_rd_pending),
    .i_flush           (i_flush),
    .o_pending_cnt     (o_pending_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_cycle  = 0;

  // Reference model: architectural values and the set of registers that
  // have an in-flight producer.
  logic [31:0] m_regs [32];
  bit          m_busy [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (rst || a == 5'd0) return 32'd0;
    if (i_wb_en && i_wb_rd == a) return i_wb_data;
    return m_regs[a];
  endfunction

  function automatic logic [31:0] exp_pend(input logic [4:0] a);
    if (rst || a == 5'd0) return 32'd0;
    if (i_wb_en && i_wb_rd == a) return 32'd0;
    return {31'd0, m_busy[a]};
  endfunction

  function automatic logic [31:0] exp_cnt();
    int n = 0;
    if (rst) return 32'd0;
    foreach (m_busy[r]) n += int'(m_busy[r]);
    return 32'(n);
  endfunction

  task automatic model_update();
    if (rst) begin
      foreach (m_regs[r]) begin
        m_regs[r] = 32'd0;
        m_busy[r] = 1'b0;
      end
    end else begin
      if (i_wb_en && i_wb_rd != 5'd0) m_regs[i_wb_rd] = i_wb_data;
      if (i_flush) begin
        foreach (m_busy[r]) m_busy[r] = 1'b0;
      end else begin
        if (i_wb_en) m_busy[i_wb_rd] = 1'b0;
        if (i_issue_valid && i_issue_writes_rd) m_busy[i_issue_rd] = 1'b1;
      end
      m_busy[0] = 1'b0;
    end
  endtask

  task automatic idle();
    rst = 1'b0; i_flush = 1'b0;
    i_wb_en = 1'b0; i_wb_rd = '0; i_wb_data = '0;
    i_rs1_addr = '0; i_rs2_addr = '0;
    i_issue_valid = 1'b0; i_issue_writes_rd = 1'b0; i_issue_rd = '0;
  endtask

  // Called shortly after a falling edge with inputs already driven: checks
  // every output against the model, then advances one clock.
  task automatic cycle(input string tag);
    #2;
    chk({tag, "/rs1_data"}, o_rs1_data, exp_read(i_rs1_addr));
    chk({tag, "/rs2_data"}, o_rs2_data, exp_read(i_rs2_addr));
    chk({tag, "/rs1_pend"}, {31'd0, o_rs1_pending}, exp_pend(i_rs1_addr));
    chk({tag, "/rs2_pend"}, {31'd0, o_rs2_pending}, exp_pend(i_rs2_addr));
    chk({tag, "/rd_pend"},  {31'd0, o_rd_pending},  exp_pend(i_issue_rd));
    chk({tag, "/cnt"},      {26'd0, o_pending_cnt}, exp_cnt());
    $display("cyc %0d %s rst=%0b fl=%0b wb=%0b x%0d=%h iss=%0b/%0b x%0d rs1=x%0d:%h rs2=x%0d:%h cnt=%0d",
             n_cycle, tag, rst, i_flush, i_wb_en, i_wb_rd, i_wb_data, i_issue_valid,
             i_issue_writes_rd, i_issue_rd, i_rs1_addr, o_rs1_data, i_rs2_addr, o_rs2_data,
             o_pending_cnt);
    @(posedge clk);
    model_update();
    n_cycle++;
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_q [$];
    foreach (m_regs[r]) begin
      m_regs[r] = 32'd0;
      m_busy[r] = 1'b0;
    end
    idle();
    @(negedge clk);

    // Reset and read everything back as zero.
    rst = 1'b1; i_rs1_addr = 5'd5; i_rs2_addr = 5'd31;
    cycle("reset");
    cycle("reset");
    rst = 1'b0;
    #1;
    chk("reset/rs2_data_const", o_rs2_data, 32'd0);
    chk("reset/cnt_const", {26'd0, o_pending_cnt}, 32'd0);
    cycle("post_reset");

    // Write then read back; x0 writes are dropped.
    i_wb_en = 1'b1; i_wb_rd = 5'd7; i_wb_data = 32'hDEADBEEF;
    cycle("wb_x7");
    idle(); i_rs1_addr = 5'd7;
    #1 chk("x7_readback", o_rs1_data, 32'hDEADBEEF);
    cycle("rd_x7");
    i_wb_en = 1'b1; i_wb_rd = 5'd0; i_wb_data = 32'h1234; i_rs2_addr = 5'd0;
    cycle("wb_x0");
    idle(); i_rs2_addr = 5'd0;
    #1 chk("x0_reads_zero", o_rs2_data, 32'd0);
    cycle("rd_x0");

    // Same-cycle bypass.
    i_wb_en = 1'b1; i_wb_rd = 5'd3; i_wb_data = 32'hA5A5A5A5; i_rs1_addr = 5'd3;
    #1 chk("bypass_x3", o_rs1_data, 32'hA5A5A5A5);
    cycle("bypass");

    // RAW through the scoreboard.
    idle(); i_issue_valid = 1'b1; i_issue_writes_rd = 1'b1; i_issue_rd = 5'd9;
    cycle("issue_x9");
    idle(); i_rs2_addr = 5'd9;
    #1 chk("raw_x9_pending", {31'd0, o_rs2_pending}, 32'd1);
    chk("raw_cnt1", {26'd0, o_pending_cnt}, 32'd1);
    cycle("raw_x9");
    i_wb_en = 1'b1; i_wb_rd = 5'd9; i_wb_data = 32'h99;
    #1 chk("raw_x9_retiring", {31'd0, o_rs2_pending}, 32'd0);
    cycle("wb_x9");
    idle(); i_rs2_addr = 5'd9;
    #1 chk("raw_cnt0", {26'd0, o_pending_cnt}, 32'd0);
    cycle("after_x9");

    // Set/clear collision: the new producer wins.
    idle(); i_issue_valid = 1'b1; i_issue_writes_rd = 1'b1; i_issue_rd = 5'd4;
    cycle("issue_x4");
    i_wb_en = 1'b1; i_wb_rd = 5'd4; i_wb_data = 32'h44;
    #1 chk("waw_masked", {31'd0, o_rd_pending}, 32'd0);
    cycle("collide_x4");
    idle(); i_rs1_addr = 5'd4; i_issue_rd = 5'd4;
    #1 chk("collide_still_pending", {31'd0, o_rs1_pending}, 32'd1);
    chk("waw_detect", {31'd0, o_rd_pending}, 32'd1);
    cycle("check_x4");
    idle(); i_wb_en = 1'b1; i_wb_rd = 5'd4; i_wb_data = 32'h45;
    cycle("retire_x4");

    // Flush alongside a write-back, then reset alongside a write-back.
    for (int r = 1; r <= 3; r++) begin
      idle(); i_issue_valid = 1'b1; i_issue_writes_rd = 1'b1; i_issue_rd = 5'(r);
      cycle("issue_123");
    end
    idle();
    #1 chk("cnt3", {26'd0, o_pending_cnt}, 32'd3);
    i_flush = 1'b1; i_wb_en = 1'b1; i_wb_rd = 5'd2; i_wb_data = 32'h55;
    cycle("flush_wb_x2");
    idle(); i_rs1_addr = 5'd2;
    #1 chk("flush_x2_written", o_rs1_data, 32'h55);
    chk("flush_cnt0", {26'd0, o_pending_cnt}, 32'd0);
    cycle("after_flush");
    rst = 1'b1; i_wb_en = 1'b1; i_wb_rd = 5'd5; i_wb_data = 32'h99;
    cycle("rst_wb_x5");
    idle(); i_rs1_addr = 5'd5;
    #1 chk("rst_beats_wb", o_rs1_data, 32'd0);
    cycle("after_rst");

    // Randomized traffic checked against the model every cycle.
    for (int n = 0; n < 600; n++) begin
      idle();
      busy_q.delete();
      for (int r = 1; r < 32; r++) if (m_busy[r]) busy_q.push_back(r);
      rst     = ($urandom_range(0, 99) == 0);
      i_flush = ($urandom_range(0, 39) == 0);
      i_wb_en = $urandom_range(0, 1) == 1;
      if (busy_q.size() > 0 && $urandom_range(0, 9) < 7)
        i_wb_rd = 5'(busy_q[$urandom_range(0, busy_q.size() - 1)]);
      else
        i_wb_rd = 5'($urandom_range(0, 31));
      i_wb_data = $urandom;
      i_issue_valid     = $urandom_range(0, 1) == 1;
      i_issue_writes_rd = $urandom_range(0, 3) != 0;
      i_issue_rd        = 5'($urandom_range(0, 31));
      // Issue stalls on a still-pending destination.
      if (exp_pend(i_issue_rd) != 32'd0 && !rst) i_issue_valid = 1'b0;
      i_rs1_addr = ($urandom_range(0, 3) == 0) ? i_wb_rd : 5'($urandom_range(0, 31));
      if (busy_q.size() > 0 && $urandom_range(0, 1) == 1)
        i_rs2_addr = 5'(busy_q[$urandom_range(0, busy_q.size() - 1)]);
      else
        i_rs2_addr = 5'($urandom_range(0, 31));
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
